// File: rtl/codec_sample_writer.sv
// Write-side FIFO between the sample-processing chain and the audio codec write port.
// Optional build macro CODEC_WRITER_HOLD_EN: on underrun, re-send the last pair instead of idling.
module codec_sample_writer #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_left,
   input  logic [WIDTH-1:0]         in_right,
   output logic                     in_ready,
   input  logic                     write_ready,
   output logic                     write,
   output logic [WIDTH-1:0]         writedata_left,
   output logic [WIDTH-1:0]         writedata_right,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   typedef enum logic {
      IDLE,
      WRITE
   } state_t;

   state_t state, next_state;

   logic [WIDTH-1:0] mem_left  [DEPTH];
   logic [WIDTH-1:0] mem_right [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic drop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign in_ready = !full && !reset;
   assign push     = in_valid && in_ready;
   assign drop     = in_valid && !in_ready && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A pop only happens from IDLE, so writes are spaced at least two cycles apart.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      write      = 1'b0;
      case (state)
         IDLE: begin
            if (write_ready && !empty) begin
               pop        = 1'b1;
               next_state = WRITE;
            end
`ifdef CODEC_WRITER_HOLD_EN
            else if (write_ready) begin
               next_state = WRITE;
            end
`endif
         end
         WRITE: begin
            write      = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_left[wr_ptr]  <= in_left;
         mem_right[wr_ptr] <= in_right;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         writedata_left  <= '0;
         writedata_right <= '0;
         overflow        <= 1'b0;
      end else begin
         if (pop) begin
            writedata_left  <= mem_left[rd_ptr];
            writedata_right <= mem_right[rd_ptr];
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
